// File: rtl/scoreboard_register_file.sv
// Register file with write-first bypass, a per-register busy scoreboard and a
// sequential clear that runs after every reset. Decode reserves and reads;
// writeback writes and releases.
//
// Ports:
//   CLK                       clock, all state changes on the rising edge
//   RESET_N                   synchronous active-low reset
//   READY                     high once the clear sequence has completed
//   RD_LE, RD, DATA_IN        write port (RD is also the destination read address)
//   RES_EN, RES_ADDR          reserve request, marks RES_ADDR busy
//   RS1, RS2                  source read addresses
//   RS1_DATA/RS2_DATA/RD_DATA registered read data
//   RS1_BUSY/RS2_BUSY/RD_BUSY registered busy flags of the addressed registers
module scoreboard_register_file #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      DEPTH       = 8,
  parameter int unsigned      AW          = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  output logic             READY,
  input  logic             RD_LE,
  input  logic [AW-1:0]    RD,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             RES_EN,
  input  logic [AW-1:0]    RES_ADDR,
  input  logic [AW-1:0]    RS1,
  input  logic [AW-1:0]    RS2,
  output logic [WIDTH-1:0] RS1_DATA,
  output logic [WIDTH-1:0] RS2_DATA,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             RS1_BUSY,
  output logic             RS2_BUSY,
  output logic             RD_BUSY
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t           state_q, state_nxt;
  logic [AW-1:0]    clr_cnt_q, clr_cnt_nxt;
  logic [DEPTH-1:0] busy_q, busy_nxt;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] wr_hit_c;
  logic [DEPTH-1:0] clr_hit_c;

  logic             ready_nxt;
  logic [WIDTH-1:0] rs1_data_nxt, rs2_data_nxt, rd_data_nxt;
  logic             rs1_busy_nxt, rs2_busy_nxt, rd_busy_nxt;

  // Per-register write/clear strobes; out-of-range addresses match nothing.
  always_comb begin
    wr_hit_c  = '0;
    clr_hit_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wr_hit_c[i]  = (state_q == S_RUN) && RD_LE && (RD == AW'(i));
      clr_hit_c[i] = (state_q == S_CLEAR) && (clr_cnt_q == AW'(i));
    end
  end

  // Next state, scoreboard update and read-port values (write-first).
  always_comb begin
    state_nxt    = state_q;
    clr_cnt_nxt  = clr_cnt_q;
    busy_nxt     = busy_q;
    ready_nxt    = 1'b0;
    rs1_data_nxt = '0;
    rs2_data_nxt = '0;
    rd_data_nxt  = '0;
    rs1_busy_nxt = 1'b0;
    rs2_busy_nxt = 1'b0;
    rd_busy_nxt  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_nxt = clr_cnt_q + AW'(1);
        if (clr_cnt_q == LAST_IDX) begin
          state_nxt = S_RUN;
          ready_nxt = 1'b1;
        end
      end
      S_RUN: begin
        ready_nxt = 1'b1;
        // Reserve is applied after the write release so a new producer wins.
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (wr_hit_c[i]) busy_nxt[i] = 1'b0;
          if (RES_EN && (RES_ADDR == AW'(i))) busy_nxt[i] = 1'b1;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (RS1 == AW'(i)) begin
            rs1_data_nxt = wr_hit_c[i] ? DATA_IN : regs_q[i];
            rs1_busy_nxt = busy_nxt[i];
          end
          if (RS2 == AW'(i)) begin
            rs2_data_nxt = wr_hit_c[i] ? DATA_IN : regs_q[i];
            rs2_busy_nxt = busy_nxt[i];
          end
          if (RD == AW'(i)) begin
            rd_data_nxt = wr_hit_c[i] ? DATA_IN : regs_q[i];
            rd_busy_nxt = busy_nxt[i];
          end
        end
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= '0;
      READY     <= 1'b0;
      RS1_DATA  <= '0;
      RS2_DATA  <= '0;
      RD_DATA   <= '0;
      RS1_BUSY  <= 1'b0;
      RS2_BUSY  <= 1'b0;
      RD_BUSY   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      clr_cnt_q <= clr_cnt_nxt;
      busy_q    <= busy_nxt;
      READY     <= ready_nxt;
      RS1_DATA  <= rs1_data_nxt;
      RS2_DATA  <= rs2_data_nxt;
      RD_DATA   <= rd_data_nxt;
      RS1_BUSY  <= rs1_busy_nxt;
      RS2_BUSY  <= rs2_busy_nxt;
      RD_BUSY   <= rd_busy_nxt;
    end
  end

  // Storage array; contents are rebuilt by the clear sequence after reset.
  always_ff @(posedge CLK) begin
    if (RESET_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (clr_hit_c[i])     regs_q[i] <= RESET_VALUE;
        else if (wr_hit_c[i]) regs_q[i] <= DATA_IN;
      end
    end
  end

endmodule
